// File: rtl/demo_sequencer_if.sv
// Control/status bundle between the demo sequencer and its neighbours.
// The master side drives frame timing and user controls; the slave side is the sequencer.
interface demo_sequencer_if #(
   parameter int unsigned TIME_BITS = 13
);
   logic                 frame_start;
   logic                 run_en;
   logic                 skip_btn;
   logic                 loop_en;
   logic [TIME_BITS-1:0] timer;
   logic                 step_pulse;
   logic                 pattern_start;
   logic                 done;
   logic [1:0]           state;

   modport master (
      output frame_start, run_en, skip_btn, loop_en,
      input  timer, step_pulse, pattern_start, done, state
   );

   modport slave (
      input  frame_start, run_en, skip_btn, loop_en,
      output timer, step_pulse, pattern_start, done, state
   );
endinterface

// File: rtl/demo_sequencer.sv
// Demo timeline sequencer: advances a pattern/position timer in frame-synchronous steps,
// with pause, debounced pattern skip and end-of-demo loop or stop.
module demo_sequencer #(
   parameter int unsigned TIME_BITS       = 13,
   parameter int unsigned FRAMES_PER_STEP = 8,
   parameter int unsigned DEBOUNCE_FRAMES = 4,
   parameter int unsigned LOOP_PATTERN    = 1
) (
   input logic             clk,
   input logic             reset,
   demo_sequencer_if.slave bus
);

   localparam int unsigned PatBits = TIME_BITS - 10;
   localparam logic [7:0] FcntLast = 8'(FRAMES_PER_STEP - 1);
   localparam logic [3:0] DbLast = 4'(DEBOUNCE_FRAMES - 1);
   localparam logic [3:0] DbMax = 4'(DEBOUNCE_FRAMES);
   localparam logic [PatBits-1:0] LoopPat = PatBits'(LOOP_PATTERN);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StPaused = 2'd2,
      StDone   = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [TIME_BITS-1:0] timer_q, timer_d;
   logic [7:0]           fcnt_q, fcnt_d;
   logic                 step_q, step_d;
   logic                 pstart_q, pstart_d;
   logic                 done_q, done_d;
   logic                 skip_req_q, skip_req_d;
   logic [3:0]           dcnt_q, dcnt_d;
   logic                 sync1_q, sync2_q;
   logic                 req_set;

   // Two-flop synchronizer for the raw asynchronous button.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bus.skip_btn;
         sync2_q <= sync1_q;
      end
   end

   // Frame-sampled debounce; a press arms exactly once until a 0 sample re-arms it.
   always_comb begin
      dcnt_d  = dcnt_q;
      req_set = 1'b0;
      if (bus.frame_start) begin
         if (sync2_q) begin
            if (dcnt_q < DbMax) begin
               dcnt_d = dcnt_q + 4'd1;
            end
            if (dcnt_q == DbLast) begin
               req_set = 1'b1;
            end
         end else begin
            dcnt_d = 4'd0;
         end
      end
   end

   // Next-state, timer and pulse logic; nothing moves except on a frame strobe.
   always_comb begin
      logic                 wrap;
      logic [TIME_BITS-1:0] timer_inc;
      logic [PatBits-1:0]   pat_inc;

      state_d    = state_q;
      timer_d    = timer_q;
      fcnt_d     = fcnt_q;
      step_d     = 1'b0;
      pstart_d   = 1'b0;
      done_d     = done_q;
      skip_req_d = skip_req_q;
      wrap       = 1'b0;
      timer_inc  = timer_q + TIME_BITS'(1);
      pat_inc    = timer_q[TIME_BITS-1:10] + PatBits'(1);

      if (bus.frame_start) begin
         unique case (state_q)
            StIdle: begin
               skip_req_d = 1'b0;
               if (bus.run_en) begin
                  state_d = StRun;
               end
            end
            StRun, StPaused: begin
               if (skip_req_q) begin
                  // Skip beats any step or pause decision on the same frame.
                  skip_req_d = 1'b0;
                  if (&timer_q[TIME_BITS-1:10]) begin
                     wrap = 1'b1;
                  end else begin
                     timer_d  = {pat_inc, 10'd0};
                     fcnt_d   = 8'd0;
                     step_d   = 1'b1;
                     pstart_d = 1'b1;
                  end
               end else if (state_q == StPaused) begin
                  if (bus.run_en) begin
                     state_d = StRun;
                  end
               end else if (!bus.run_en) begin
                  state_d = StPaused;
               end else if (fcnt_q == FcntLast) begin
                  fcnt_d = 8'd0;
                  if (&timer_q) begin
                     wrap = 1'b1;
                  end else begin
                     timer_d  = timer_inc;
                     step_d   = 1'b1;
                     pstart_d = (timer_inc[9:0] == 10'd0);
                  end
               end else begin
                  fcnt_d = fcnt_q + 8'd1;
               end
               if (req_set) begin
                  skip_req_d = 1'b1;
               end
            end
            StDone: begin
               skip_req_d = 1'b0;
            end
            default: begin
               state_d = StIdle;
            end
         endcase

         if (wrap) begin
            if (bus.loop_en) begin
               timer_d  = {LoopPat, 10'd0};
               fcnt_d   = 8'd0;
               step_d   = 1'b1;
               pstart_d = 1'b1;
            end else begin
               state_d = StDone;
               done_d  = 1'b1;
            end
         end
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         fcnt_q     <= 8'd0;
         step_q     <= 1'b0;
         pstart_q   <= 1'b0;
         done_q     <= 1'b0;
         skip_req_q <= 1'b0;
         dcnt_q     <= 4'd0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         fcnt_q     <= fcnt_d;
         step_q     <= step_d;
         pstart_q   <= pstart_d;
         done_q     <= done_d;
         skip_req_q <= skip_req_d;
         dcnt_q     <= dcnt_d;
      end
   end

   assign bus.timer         = timer_q;
   assign bus.step_pulse    = step_q;
   assign bus.pattern_start = pstart_q;
   assign bus.done          = done_q;
   assign bus.state         = state_q;

endmodule

// File: tb/tb_demo_sequencer.sv
// Directed bench for demo_sequencer with FRAMES_PER_STEP=2, DEBOUNCE_FRAMES=4, LOOP_PATTERN=1.
module tb_demo_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   demo_sequencer_if #(.TIME_BITS(13)) bus ();

   demo_sequencer #(
      .TIME_BITS      (13),
      .FRAMES_PER_STEP(2),
      .DEBOUNCE_FRAMES(4),
      .LOOP_PATTERN   (1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // n back-to-back frame strobes; returns at a negedge with the last frame's results visible.
   task automatic run_frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.frame_start = 1'b1;
      end
      @(negedge clk);
      bus.frame_start = 1'b0;
   endtask

   task automatic set_skip(input logic v);
      bus.skip_btn = v;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      bus.frame_start = 1'b0;
      bus.run_en      = 1'b0;
      bus.skip_btn    = 1'b0;
      bus.loop_en     = 1'b1;
      reset           = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if (bus.timer !== 13'h0) begin
         n_fail++; $display("FAIL reset_timer: got %h expected 0000", bus.timer);
      end
      n_checks++;
      if (bus.state !== 2'd0) begin
         n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state);
      end
      n_checks++;
      if ({bus.step_pulse, bus.pattern_start, bus.done} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 000",
                  {bus.step_pulse, bus.pattern_start, bus.done});
      end
   endtask

   task automatic test_run_step();
      bus.run_en = 1'b1;
      run_frames(1);
      n_checks++;
      if (bus.state !== 2'd1 || bus.timer !== 13'h0 || bus.step_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL run_enter: got state %0d timer %h step %b expected 1 0000 0",
                  bus.state, bus.timer, bus.step_pulse);
      end
      run_frames(2);
      n_checks++;
      if (bus.timer !== 13'h1 || bus.step_pulse !== 1'b1 || bus.pattern_start !== 1'b0) begin
         n_fail++;
         $display("FAIL run_step1: got timer %h step %b pstart %b expected 0001 1 0",
                  bus.timer, bus.step_pulse, bus.pattern_start);
      end
      @(negedge clk);
      n_checks++;
      if (bus.step_pulse !== 1'b0) begin
         n_fail++; $display("FAIL step_one_cycle: got %b expected 0", bus.step_pulse);
      end
      run_frames(2);
      n_checks++;
      if (bus.timer !== 13'h2 || bus.step_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL run_step2: got timer %h step %b expected 0002 1",
                  bus.timer, bus.step_pulse);
      end
   endtask

   task automatic test_pause();
      run_frames(7);   // timer 5, fcnt 1
      n_checks++;
      if (bus.timer !== 13'h5) begin
         n_fail++; $display("FAIL pause_setup: got %h expected 0005", bus.timer);
      end
      bus.run_en = 1'b0;
      run_frames(10);
      n_checks++;
      if (bus.state !== 2'd2 || bus.timer !== 13'h5) begin
         n_fail++;
         $display("FAIL pause_hold: got state %0d timer %h expected 2 0005",
                  bus.state, bus.timer);
      end
      bus.run_en = 1'b1;
      run_frames(1);
      n_checks++;
      if (bus.state !== 2'd1 || bus.timer !== 13'h5) begin
         n_fail++;
         $display("FAIL pause_resume: got state %0d timer %h expected 1 0005",
                  bus.state, bus.timer);
      end
      run_frames(1);
      n_checks++;
      if (bus.timer !== 13'h6 || bus.step_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL pause_fcnt_kept: got timer %h step %b expected 0006 1",
                  bus.timer, bus.step_pulse);
      end
   endtask

   task automatic test_skip_debounce();
      run_frames(570);   // timer 0x123, fcnt 0
      set_skip(1'b1);
      run_frames(3);
      set_skip(1'b0);
      run_frames(3);
      n_checks++;
      if (bus.timer !== 13'h126 || bus.pattern_start !== 1'b0) begin
         n_fail++;
         $display("FAIL skip_short_press: got timer %h pstart %b expected 0126 0",
                  bus.timer, bus.pattern_start);
      end
      set_skip(1'b1);
      run_frames(4);
      n_checks++;
      if (bus.timer !== 13'h128) begin
         n_fail++; $display("FAIL skip_not_yet: got %h expected 0128", bus.timer);
      end
      run_frames(1);
      n_checks++;
      if (bus.timer !== 13'h400 || bus.pattern_start !== 1'b1 || bus.step_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL skip_jump: got timer %h pstart %b step %b expected 0400 1 1",
                  bus.timer, bus.pattern_start, bus.step_pulse);
      end
      run_frames(4);
      n_checks++;
      if (bus.timer !== 13'h402) begin
         n_fail++; $display("FAIL skip_once: got %h expected 0402", bus.timer);
      end
      set_skip(1'b0);
      run_frames(1);   // timer 0x402, fcnt 1
   endtask

   task automatic test_collision();
      run_frames(2038);   // timer 0x7FD, fcnt 1
      set_skip(1'b1);
      run_frames(4);
      n_checks++;
      if (bus.timer !== 13'h7FF) begin
         n_fail++; $display("FAIL coll_setup: got %h expected 07ff", bus.timer);
      end
      run_frames(1);
      n_checks++;
      if (bus.timer !== 13'h800 || bus.pattern_start !== 1'b1) begin
         n_fail++;
         $display("FAIL coll_skip_wins: got timer %h pstart %b expected 0800 1",
                  bus.timer, bus.pattern_start);
      end
      set_skip(1'b0);
      run_frames(1);
      n_checks++;
      if (bus.timer !== 13'h800) begin
         n_fail++; $display("FAIL coll_fcnt_cleared: got %h expected 0800", bus.timer);
      end
      run_frames(1);
      n_checks++;
      if (bus.timer !== 13'h801) begin
         n_fail++; $display("FAIL coll_next_step: got %h expected 0801", bus.timer);
      end
   endtask

   task automatic test_end_loop_stop();
      run_frames(12285);   // timer 0x1FFF, fcnt 1
      n_checks++;
      if (bus.timer !== 13'h1FFF) begin
         n_fail++; $display("FAIL end_setup: got %h expected 1fff", bus.timer);
      end
      bus.loop_en = 1'b1;
      run_frames(1);
      n_checks++;
      if (bus.timer !== 13'h400 || bus.pattern_start !== 1'b1 || bus.step_pulse !== 1'b1 ||
          bus.state !== 2'd1) begin
         n_fail++;
         $display("FAIL end_loop: got timer %h pstart %b step %b state %0d expected 0400 1 1 1",
                  bus.timer, bus.pattern_start, bus.step_pulse, bus.state);
      end
      run_frames(14335);   // timer 0x1FFF, fcnt 1
      bus.loop_en = 1'b0;
      run_frames(1);
      n_checks++;
      if (bus.timer !== 13'h1FFF || bus.done !== 1'b1 || bus.state !== 2'd3 ||
          bus.step_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL end_stop: got timer %h done %b state %0d step %b expected 1fff 1 3 0",
                  bus.timer, bus.done, bus.state, bus.step_pulse);
      end
      set_skip(1'b1);
      run_frames(6);
      set_skip(1'b0);
      bus.run_en = 1'b0;
      run_frames(2);
      n_checks++;
      if (bus.timer !== 13'h1FFF || bus.done !== 1'b1 || bus.state !== 2'd3) begin
         n_fail++;
         $display("FAIL done_hold: got timer %h done %b state %0d expected 1fff 1 3",
                  bus.timer, bus.done, bus.state);
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      @(negedge clk);
      reset       = 1'b0;
      bus.run_en  = 1'b1;
      bus.loop_en = 1'b1;
      run_frames(1);
      run_frames(5290);   // timer 0xA55, fcnt 0
      bus.run_en = 1'b0;
      run_frames(1);
      set_skip(1'b1);
      run_frames(4);      // skip now pending while paused
      n_checks++;
      if (bus.timer !== 13'hA55 || bus.state !== 2'd2) begin
         n_fail++;
         $display("FAIL mid_setup: got timer %h state %0d expected 0a55 2",
                  bus.timer, bus.state);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if (bus.timer !== 13'h0 || bus.state !== 2'd0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got timer %h state %0d done %b expected 0000 0 0",
                  bus.timer, bus.state, bus.done);
      end
      set_skip(1'b0);
      bus.run_en = 1'b1;
      run_frames(3);
      n_checks++;
      if (bus.timer !== 13'h1 || bus.pattern_start !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_stale_skip: got timer %h pstart %b expected 0001 0",
                  bus.timer, bus.pattern_start);
      end
   endtask

   initial begin
      test_reset();
      test_run_step();
      test_pause();
      test_skip_debounce();
      test_collision();
      test_end_loop_stop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
